// File: rtl/apb_slave_mux_if.sv
// APB fabric bundle between the AHB-to-APB interface FSM, the slave mux and the APB slaves.
// The mux takes the slave modport; the upstream FSM plus slaves form the master side.
interface apb_slave_mux_if #(
  parameter int NUM_SLV        = 4,
  parameter int PADDR_WIDTH    = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic                              psel_en;
  logic                              penable;
  logic [PADDR_WIDTH-1:0]            paddr;
  logic [NUM_SLV-1:0]                psel;
  logic [NUM_SLV-1:0]                pready_s;
  logic [NUM_SLV-1:0]                pslverr_s;
  logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata_s;
  logic                              pready_x;
  logic                              pslverr_x;
  logic [APB_DATA_WIDTH-1:0]         prdata_x;

  modport slave (
    input  psel_en, penable, paddr, pready_s, pslverr_s, prdata_s,
    output psel, pready_x, pslverr_x, prdata_x
  );

  modport master (
    output psel_en, penable, paddr, pready_s, pslverr_s, prdata_s,
    input  psel, pready_x, pslverr_x, prdata_x
  );
endinterface

// File: rtl/apb_slave_mux.sv
// APB slave decoder/mux: one-hot psel from paddr, per-transfer target latch,
// error response for unmapped addresses and for slaves that exceed the wait-state timeout.
module apb_slave_mux #(
  parameter int NUM_SLV        = 4,
  parameter int PADDR_WIDTH    = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int SEL_LSB        = 12,
  parameter int SEL_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              hclk,
  input  logic              hreset_n,
  apb_slave_mux_if.slave    bus,
  output logic              busy,
  output logic [7:0]        tmo_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [SEL_BITS-1:0]       idx_q, idx_d;
  logic                      mapped_q, mapped_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [7:0]                tmo_q, tmo_d;

  logic [SEL_BITS-1:0]       idx_live;
  logic [31:0]               idx_live_ext;
  logic                      mapped_live;
  logic                      slv_ready;
  logic                      slv_err;
  logic [APB_DATA_WIDTH-1:0] slv_data;

  logic [NUM_SLV-1:0]        psel_c;
  logic                      pready_c;
  logic                      pslverr_c;
  logic [APB_DATA_WIDTH-1:0] prdata_c;
  logic                      unused_paddr;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [SEL_BITS-1:0] i);
    logic [NUM_SLV-1:0] r;
    for (int s = 0; s < NUM_SLV; s++) r[s] = (i == SEL_BITS'(s));
    return r;
  endfunction

  assign idx_live     = bus.paddr[SEL_LSB +: SEL_BITS];
  assign idx_live_ext = 32'(idx_live);
  assign mapped_live  = (idx_live_ext < 32'(NUM_SLV));
  assign unused_paddr = ^bus.paddr;

  // Response mux keyed on the latched index; an unmapped index simply selects nothing.
  always_comb begin
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    slv_data  = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (idx_q == SEL_BITS'(s)) begin
        slv_ready = bus.pready_s[s];
        slv_err   = bus.pslverr_s[s];
        slv_data  = bus.prdata_s[s*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    mapped_d  = mapped_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    psel_c    = '0;
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    prdata_c  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.psel_en && mapped_live) psel_c = onehot(idx_live);
        if (bus.psel_en) begin
          idx_d    = idx_live;
          mapped_d = mapped_live;
          cnt_d    = '0;
          state_d  = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (!bus.psel_en) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          if (mapped_q) psel_c = onehot(idx_q);
          if (bus.penable) begin
            if (!mapped_q) begin
              pready_c  = 1'b1;
              pslverr_c = 1'b1;
              state_d   = ST_DONE;
            end else if (slv_ready) begin
              pready_c  = 1'b1;
              pslverr_c = slv_err;
              prdata_c  = slv_data;
              state_d   = ST_DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
              pready_c  = 1'b1;
              pslverr_c = 1'b1;
              tmo_d     = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
              state_d   = ST_DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end

      ST_DONE: begin
        if (!bus.psel_en) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs read as reset values for the whole cycle reset is asserted, not only after the edge.
    if (!hreset_n) begin
      psel_c    = '0;
      pready_c  = 1'b0;
      pslverr_c = 1'b0;
      prdata_c  = '0;
    end
  end

  always_ff @(posedge hclk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!hreset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mapped_q <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mapped_q <= mapped_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.psel      = psel_c;
  assign bus.pready_x  = pready_c;
  assign bus.pslverr_x = pslverr_c;
  assign bus.prdata_x  = prdata_c;
  assign busy          = (state_q != ST_IDLE);
  assign tmo_count     = tmo_q;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Directed bench for apb_slave_mux (3 slaves so index 3 is unmapped); stimulus pushes the
// expected response, a negedge monitor pops and compares on every pready_x pulse.
module tb_apb_slave_mux;

  localparam int NS  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  logic       hclk;
  logic       hreset_n;
  logic       busy;
  logic [7:0] tmo_count;

  int    checks   = 0;
  int    failures = 0;
  resp_t exp_q[$];
  resp_t mon_e;

  apb_slave_mux_if #(.NUM_SLV(NS), .PADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  apb_slave_mux #(
    .NUM_SLV(NS), .PADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
    .SEL_LSB(12), .SEL_BITS(2), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .bus       (bus),
    .busy      (busy),
    .tmo_count (tmo_count)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every pready_x pulse must match the oldest outstanding expectation.
  always @(negedge hclk) begin
    if (hreset_n === 1'b1) begin
      if (bus.pready_x === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_pslverr", 64'(bus.pslverr_x), 64'(mon_e.err));
          check("resp_prdata", 64'(bus.prdata_x), 64'(mon_e.data));
        end
      end else begin
        check("quiet_outputs", {31'd0, bus.pslverr_x, bus.prdata_x}, 64'd0);
      end
    end
  end

  task automatic drive_slaves(input int slv, input logic [DW-1:0] rdata);
    for (int i = 0; i < NS; i++)
      bus.prdata_s[i*DW +: DW] = (i == slv) ? rdata : (32'hD000_0000 + 32'(i));
  endtask

  // One full transfer: SETUP, ACCESS until response (bounded), one DONE cycle, then psel_en drop.
  task automatic xfer(input string name, input logic [AW-1:0] addr, input logic [AW-1:0] addr2,
                      input int slv, input int waits, input logic err, input logic [DW-1:0] rdata,
                      input logic [NS-1:0] exp_psel, input logic exp_err, input logic [DW-1:0] exp_data,
                      input int exp_cycles);
    logic [NS-1:0] one_slv;
    bit            seen;
    int            k;
    one_slv = NS'(1) << slv;
    @(posedge hclk); #1;
    bus.psel_en   = 1'b1;
    bus.penable   = 1'b0;
    bus.paddr     = addr;
    bus.pready_s  = '0;
    bus.pslverr_s = '0;
    drive_slaves(slv, rdata);
    exp_q.push_back('{exp_err, exp_data});
    @(negedge hclk);
    check({name, "_setup_psel"}, 64'(bus.psel), 64'(exp_psel));
    check({name, "_setup_busy"}, 64'(busy), 64'd0);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      @(posedge hclk); #1;
      bus.penable   = 1'b1;
      if (k >= 1) bus.paddr = addr2;
      bus.pready_s  = (waits >= 0 && k == waits) ? one_slv : '0;
      bus.pslverr_s = err ? one_slv : '0;
      @(negedge hclk);
      check({name, "_access_psel"}, 64'(bus.psel), 64'(exp_psel));
      check({name, "_access_busy"}, 64'(busy), 64'd1);
      if (bus.pready_x === 1'b1) seen = 1'b1;
      k++;
    end
    check({name, "_access_cycles"}, 64'(k), 64'(exp_cycles));
    if (!seen && exp_q.size() != 0) void'(exp_q.pop_back());
    @(posedge hclk); #1;
    bus.pready_s = '0;
    @(negedge hclk);
    check({name, "_done_psel"}, 64'(bus.psel), 64'd0);
    check({name, "_done_busy"}, 64'(busy), 64'd1);
    @(posedge hclk); #1;
    bus.psel_en   = 1'b0;
    bus.penable   = 1'b0;
    bus.pslverr_s = '0;
  endtask

  // Starts a slave-1/2 transfer that never gets ready; returns in ACTIVE after n ACCESS cycles.
  task automatic start_waited(input logic [AW-1:0] addr, input int n);
    @(posedge hclk); #1;
    bus.psel_en  = 1'b1;
    bus.penable  = 1'b0;
    bus.paddr    = addr;
    bus.pready_s = '0;
    repeat (n) begin
      @(posedge hclk); #1;
      bus.penable = 1'b1;
    end
  endtask

  initial begin
    hreset_n      = 1'b0;
    bus.psel_en   = 1'b0;
    bus.penable   = 1'b0;
    bus.paddr     = '0;
    bus.pready_s  = '0;
    bus.pslverr_s = '0;
    bus.prdata_s  = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst_psel", 64'(bus.psel), 64'd0);
    check("rst_pready", 64'(bus.pready_x), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tmo", 64'(tmo_count), 64'd0);
    @(posedge hclk); #1;
    hreset_n = 1'b1;

    xfer("t1_read_s1", 32'h0000_1000, 32'h0000_1000, 1, 0, 1'b0, 32'hA5A5_0001,
         3'b010, 1'b0, 32'hA5A5_0001, 1);
    xfer("t2_wait3_s2", 32'h0000_2000, 32'h0000_2000, 2, 3, 1'b0, 32'h1234_5678,
         3'b100, 1'b0, 32'h1234_5678, 4);
    check("t2_tmo", 64'(tmo_count), 64'd0);
    xfer("t3_unmapped", 32'h0000_3000, 32'h0000_3000, 0, -1, 1'b0, 32'hDEAD_BEEF,
         3'b000, 1'b1, 32'h0, 1);
    xfer("t4_timeout_s0", 32'h0000_0000, 32'h0000_0000, 0, -1, 1'b0, 32'hCAFE_0000,
         3'b001, 1'b1, 32'h0, TMO);
    check("t4_tmo", 64'(tmo_count), 64'd1);
    xfer("t5_ready_at_limit", 32'h0000_1004, 32'h0000_1004, 1, TMO - 1, 1'b0, 32'h0BAD_F00D,
         3'b010, 1'b0, 32'h0BAD_F00D, TMO);
    check("t5_tmo", 64'(tmo_count), 64'd1);
    xfer("t6_err_latched", 32'h0000_2010, 32'h0000_0010, 2, 2, 1'b1, 32'h5555_AAAA,
         3'b100, 1'b1, 32'h5555_AAAA, 3);

    // Abort mid-ACCESS: no response, and the wait counter must restart for the next transfer.
    start_waited(32'h0000_1000, 3);
    bus.psel_en = 1'b0;
    bus.penable = 1'b0;
    @(negedge hclk);
    check("abort_psel", 64'(bus.psel), 64'd0);
    @(posedge hclk); #1;
    @(negedge hclk);
    check("abort_busy", 64'(busy), 64'd0);
    xfer("t7_timeout_after_abort", 32'h0000_0000, 32'h0000_0000, 0, -1, 1'b0, 32'h7777_0000,
         3'b001, 1'b1, 32'h0, TMO);
    check("t7_tmo", 64'(tmo_count), 64'd2);

    // Reset during a waited ACCESS.
    start_waited(32'h0000_2000, 5);
    hreset_n = 1'b0;
    @(negedge hclk);
    check("rst_mid_psel", 64'(bus.psel), 64'd0);
    @(posedge hclk); #1;
    hreset_n    = 1'b1;
    bus.psel_en = 1'b0;
    bus.penable = 1'b0;
    @(negedge hclk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_psel_after", 64'(bus.psel), 64'd0);
    check("rst_mid_tmo", 64'(tmo_count), 64'd0);
    xfer("t8_after_reset", 32'h0000_2000, 32'h0000_2000, 2, 1, 1'b0, 32'h0F0F_1234,
         3'b100, 1'b0, 32'h0F0F_1234, 2);
    check("t8_tmo", 64'(tmo_count), 64'd0);

    repeat (2) @(posedge hclk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
